serial_slave_param: RTL and testbench
=====================================

# serial_slave_param

Parametrised bit-serial bus slave with on-chip register memory. Serves the serial master/arbiter bus (validIn, wren, serial Address/DataIn, ready, validOut, DataOut) with configurable address/data widths, memory depth, slave-ID decoding, programmable read latency and incrementing burst transfers. It replaces the fixed-width single-transfer slave, keeping the same bus-side port names.

## Interface
- ADDR_WIDTH, 12: serial address bits per transaction, MSB first.
- DATA_WIDTH, 8: bits per data word, MSB first.
- MEM_DEPTH, 256: words of storage; power of two; MEM_AW = clog2(MEM_DEPTH) ≤ ADDR_WIDTH.
- SLAVE_ID, 4'h2: compared with address bits [ADDR_WIDTH-1:MEM_AW]; if ADDR_WIDTH == MEM_AW, every address matches.
- READ_LATENCY, 2: idle cycles between address completion and the first read bit; 0 allowed.
- clk  in  1  single clock; all state changes on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- validIn  in  1  master qualifier for address and write-data bits; burst-continue request.
- wren  in  1  1 = write, 0 = read; sampled at the start edge only.
- Address  in  1  serial address bit.
- DataIn  in  1  serial write-data bit.
- ready  out  1  one-cycle pulse: write address accepted, slave takes data.
- validOut  out  1  high while DataOut carries a read bit.
- DataOut  out  1  serial read-data bit; 0 when validOut = 0.

## Operation
- States: IDLE, ADDR, WREADY, WDATA, RLAT, RDATA, DROP.
- IDLE: edge with validIn = 1 is the start edge E0; latch wren; go ADDR; bit counter = 0.
- ADDR: edges E1..E_A (A = ADDR_WIDTH) shift in Address, MSB first; validIn must stay 1. validIn = 0 at any sampled edge aborts to IDLE, no response.
- At E_A: ID compare on upper bits. Mismatch → DROP (no ready, no validOut) until validIn sampled 0, then IDLE. Match + write → WREADY. Match + read → RLAT (or RDATA if READ_LATENCY = 0).
- WREADY: ready = 1 for exactly one cycle, then WDATA.
- WDATA: first data bit sampled at first edge with validIn = 1 after the ready pulse (unbounded wait). The remaining DATA_WIDTH-1 bits are sampled on consecutive edges with validIn = 1. validIn = 0 mid-word aborts to IDLE and the partial word is discarded. At the edge sampling the last bit, mem[addr] is written and addr increments modulo MEM_DEPTH. At the following edge, validIn = 1 samples bit 0 of the next burst word; validIn = 0 returns to IDLE.
- RLAT: count READ_LATENCY cycles; validIn and Address are ignored.
- RDATA: shift mem[addr] out MSB first over DATA_WIDTH cycles with validOut = 1. validIn sampled at the edge ending the last bit: 1 → next word mem[addr+1 mod MEM_DEPTH] follows immediately with no gap and no latency; 0 → IDLE, with validOut and DataOut 0 from that edge.
- Memory is not cleared by reset; unwritten locations are undefined to the bench.
- Async reset (any state): state IDLE, counters 0, ready = validOut = DataOut = 0 immediately; memory contents retained.

## Timing
- Reset values: ready 0, validOut 0, DataOut 0; all outputs registered.
- Write: ready high during the cycle after E_A (set at E_A, cleared at E_A+1). Memory updated at the last-data-bit edge and readable by a transaction starting on the next edge.
- Read: validOut rises at edge E_A + READ_LATENCY + 1 and stays high for DATA_WIDTH × words cycles.
- Minimum IDLE-to-IDLE for a single read: 1 + A + READ_LATENCY + DATA_WIDTH edges.
- Back-to-back transactions: IDLE accepts a new start on the edge after returning.

## Test plan
- Defaults; write 0x225 ← 0xB5, then read 0x225 → ready pulses once 1 cycle after E_A; read returns 1,0,1,1,0,1,0,1 with validOut rising at E_A+3 for 8 cycles.
- Burst write at 0x2FF of 0x11 then 0x22 (validIn held), then single reads → mem[0xFF] = 0x11, mem[0x00] = 0x22 (wrap). A 2-word burst read from 0x2FF streams 0x11, 0x22 contiguously over 16 validOut cycles.
- Write to 0x325 (ID mismatch) with data bits sent anyway → ready never asserts; mem[0x25] unchanged; DROP exits when validIn = 0; the next valid read succeeds.
- Abort: drop validIn after 5 address bits, then after 3 write-data bits → no ready or validOut from the first abort; no memory change from the second; FSM in IDLE.
- READ_LATENCY = 0 instance: read 0x210 → validOut rises at E_A+1.
- Assert rstn low mid read burst → validOut/DataOut go 0 without a clock edge; after release, reading the same address returns the pre-reset data.

Source files
------------

// File: rtl/serial_slave_param.sv
// Bit-serial bus slave with on-chip register memory, slave-ID decode,
// programmable read latency and incrementing burst transfers.
module serial_slave_param #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int unsigned SLAVE_ID     = 4'h2,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic validIn,
    input  logic wren,
    input  logic Address,
    input  logic DataIn,
    output logic ready,
    output logic validOut,
    output logic DataOut
);

    localparam int unsigned MemAw  = $clog2(MEM_DEPTH);
    localparam int unsigned IdW    = ADDR_WIDTH - MemAw;
    localparam int unsigned CntLim = (ADDR_WIDTH > DATA_WIDTH) ?
        ((ADDR_WIDTH > READ_LATENCY) ? ADDR_WIDTH : READ_LATENCY) :
        ((DATA_WIDTH > READ_LATENCY) ? DATA_WIDTH : READ_LATENCY);
    localparam int unsigned CntW   = (CntLim > 2) ? $clog2(CntLim) : 1;

    typedef enum logic [2:0] {
        StIdle, StAddr, StWready, StWdata, StRlat, StRdata, StDrop
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    wr_q, wr_d;
    logic                    cont_q, cont_d;
    logic [ADDR_WIDTH-2:0]   ash_q, ash_d;
    logic [MemAw-1:0]        ptr_q, ptr_d;
    logic [DATA_WIDTH-2:0]   wsh_q, wsh_d;
    logic [DATA_WIDTH-1:0]   rsh_q, rsh_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic                    dout_q, dout_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [ADDR_WIDTH-1:0]   full_addr;
    logic                    id_match;
    logic                    last_addr, last_bit, last_lat;

    assign full_addr = {ash_q, Address};
    assign wr_word   = {wsh_q, DataIn};
    assign rd_word   = mem[ptr_q];
    assign last_addr = (cnt_q == CntW'(ADDR_WIDTH - 1));
    assign last_bit  = (cnt_q == CntW'(DATA_WIDTH - 1));
    assign last_lat  = (cnt_q == CntW'(READ_LATENCY - 1));

    if (IdW > 0) begin : g_id
        assign id_match = (full_addr[ADDR_WIDTH-1:MemAw] == IdW'(SLAVE_ID));
    end else begin : g_no_id
        assign id_match = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            cont_q  <= 1'b0;
            ash_q   <= '0;
            ptr_q   <= '0;
            wsh_q   <= '0;
            rsh_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            cont_q  <= cont_d;
            ash_q   <= ash_d;
            ptr_q   <= ptr_d;
            wsh_q   <= wsh_d;
            rsh_q   <= rsh_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive rstn.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= wr_word;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (validIn) state_d = StAddr;
            StAddr: begin
                if (!validIn) begin
                    state_d = StIdle;
                end else if (last_addr) begin
                    if (!id_match)                state_d = StDrop;
                    else if (wr_q)                state_d = StWready;
                    else if (READ_LATENCY == 0)   state_d = StRdata;
                    else                          state_d = StRlat;
                end
            end
            StWready: state_d = StWdata;
            // Before the first word the master may stall indefinitely; later a
            // low validIn on a word boundary or mid-word ends the transfer.
            StWdata:  if (!validIn && (cnt_q != '0 || cont_q)) state_d = StIdle;
            StRlat:   if (last_lat) state_d = StRdata;
            StRdata:  if (cnt_q == '0 && cont_q && !validIn) state_d = StIdle;
            StDrop:   if (!validIn) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        cont_d  = cont_q;
        ash_d   = ash_q;
        ptr_d   = ptr_q;
        wsh_d   = wsh_q;
        rsh_d   = rsh_q;
        ready_d = (state_d == StWready);
        valid_d = 1'b0;
        dout_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                cont_d = 1'b0;
                if (validIn) wr_d = wren;
            end
            StAddr: begin
                if (validIn) begin
                    ash_d = full_addr[ADDR_WIDTH-2:0];
                    if (last_addr) begin
                        cnt_d = '0;
                        ptr_d = full_addr[MemAw-1:0];
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StWready: cnt_d = '0;
            StWdata: begin
                if (validIn) begin
                    wsh_d = wr_word[DATA_WIDTH-2:0];
                    if (last_bit) begin
                        mem_we = 1'b1;
                        cnt_d  = '0;
                        cont_d = 1'b1;
                        ptr_d  = ptr_q + MemAw'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StRlat: cnt_d = last_lat ? '0 : cnt_q + CntW'(1);
            StRdata: begin
                if (state_d == StRdata) begin
                    valid_d = 1'b1;
                    if (cnt_q == '0) begin
                        dout_d = rd_word[DATA_WIDTH-1];
                        rsh_d  = {rd_word[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        dout_d = rsh_q[DATA_WIDTH-1];
                        rsh_d  = {rsh_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (last_bit) begin
                        cnt_d  = '0;
                        cont_d = 1'b1;
                        ptr_d  = ptr_q + MemAw'(1);
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDrop: cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    assign ready    = ready_q;
    assign validOut = valid_q;
    assign DataOut  = dout_q;

endmodule

// File: tb/tb_serial_slave_param.sv
// Directed bench for serial_slave_param: default instance plus a zero-latency
// instance, each on its own bus, checked with immediate assertions.
module tb_serial_slave_param;

    logic       clk;
    logic       rstn;
    logic [1:0] vin, wen, adr, din;
    logic [1:0] rdy, vo, dout;

    int nvec  = 0;
    int nfail = 0;

    serial_slave_param u_dut0 (
        .clk      (clk),
        .rstn     (rstn),
        .validIn  (vin[0]),
        .wren     (wen[0]),
        .Address  (adr[0]),
        .DataIn   (din[0]),
        .ready    (rdy[0]),
        .validOut (vo[0]),
        .DataOut  (dout[0])
    );

    serial_slave_param #(.READ_LATENCY(0)) u_dut1 (
        .clk      (clk),
        .rstn     (rstn),
        .validIn  (vin[1]),
        .wren     (wen[1]),
        .Address  (adr[1]),
        .DataIn   (din[1]),
        .ready    (rdy[1]),
        .validOut (vo[1]),
        .DataOut  (dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_hdr(input int s, input logic w, input logic [11:0] a);
        vin[s] = 1'b1;
        wen[s] = w;
        tick();
        wen[s] = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            adr[s] = a[i];
            tick();
        end
    endtask

    // Ready/validOut are tallied from E_A onwards; nothing is expected earlier.
    task automatic do_write(input int s, input logic [11:0] a, input int gap,
                            input logic [7:0] d0, input logic [7:0] d1, input int words,
                            output int rdy_ea, output int rdy_cnt, output int vo_cnt);
        logic [7:0] w;
        send_hdr(s, 1'b1, a);
        rdy_ea  = int'(rdy[s]);
        rdy_cnt = int'(rdy[s]);
        vo_cnt  = int'(vo[s]);
        tick();
        rdy_cnt += int'(rdy[s]);
        vo_cnt  += int'(vo[s]);
        vin[s] = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            rdy_cnt += int'(rdy[s]);
            vo_cnt  += int'(vo[s]);
        end
        for (int wd = 0; wd < words; wd++) begin
            w = (wd == 0) ? d0 : d1;
            for (int b = 7; b >= 0; b--) begin
                vin[s] = 1'b1;
                din[s] = w[b];
                tick();
                rdy_cnt += int'(rdy[s]);
                vo_cnt  += int'(vo[s]);
            end
        end
        vin[s] = 1'b0;
        tick();
        rdy_cnt += int'(rdy[s]);
        vo_cnt  += int'(vo[s]);
    endtask

    // first_k counts edges after E_A at which validOut was first seen high.
    task automatic do_read(input int s, input logic [11:0] a, input int words,
                           input int stop_bits, output logic [15:0] data,
                           output int first_k, output int nbits, output int span,
                           output int end_vo, output int done);
        int last_k;
        send_hdr(s, 1'b0, a);
        data    = '0;
        nbits   = 0;
        first_k = -1;
        last_k  = -1;
        end_vo  = -1;
        done    = 0;
        for (int k = 1; k <= 40; k++) begin
            if (stop_bits > 0 && nbits == stop_bits) break;
            vin[s] = (nbits < 8 * words) ? 1'b1 : 1'b0;
            tick();
            if (vo[s] === 1'b1) begin
                data = {data[14:0], dout[s]};
                nbits++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
            if (vin[s] == 1'b0) begin
                end_vo = int'(vo[s]);
                done   = 1;
                break;
            end
        end
        span = last_k - first_k + 1;
        if (stop_bits == 0) vin[s] = 1'b0;
    endtask

    logic [15:0] data;
    int fk, nb, sp, ev, dn, re, rc, vc, mon;

    initial begin
        rstn = 1'b0;
        vin  = '0;
        wen  = '0;
        adr  = '0;
        din  = '0;
        repeat (2) tick();
        check("rst_ready", 32'(rdy[0]), 32'h0);
        check("rst_validout", 32'(vo[0]), 32'h0);
        check("rst_dataout", 32'(dout[0]), 32'h0);
        check("rst_validout_rl0", 32'(vo[1]), 32'h0);
        #2 rstn = 1'b1;
        tick();

        // Single write with a two-cycle master stall before data.
        do_write(0, 12'h225, 2, 8'hB5, 8'h00, 1, re, rc, vc);
        check("wr225_ready_at_ea", 32'(re), 32'h1);
        check("wr225_ready_pulses", 32'(rc), 32'h1);
        do_read(0, 12'h225, 1, 0, data, fk, nb, sp, ev, dn);
        check("rd225_done", 32'(dn), 32'h1);
        check("rd225_data", 32'(data[7:0]), 32'hB5);
        check("rd225_first_edge", 32'(fk), 32'h3);
        check("rd225_bits", 32'(nb), 32'h8);
        check("rd225_span", 32'(sp), 32'h8);
        check("rd225_end_validout", 32'(ev), 32'h0);

        // Burst write wrapping 0xFF -> 0x00.
        do_write(0, 12'h2FF, 0, 8'h11, 8'h22, 2, re, rc, vc);
        check("burstwr_ready_pulses", 32'(rc), 32'h1);
        do_read(0, 12'h2FF, 1, 0, data, fk, nb, sp, ev, dn);
        check("rd2ff_data", 32'(data[7:0]), 32'h11);
        do_read(0, 12'h200, 1, 0, data, fk, nb, sp, ev, dn);
        check("rd200_data", 32'(data[7:0]), 32'h22);
        do_read(0, 12'h2FF, 2, 0, data, fk, nb, sp, ev, dn);
        check("burstrd_done", 32'(dn), 32'h1);
        check("burstrd_data", 32'(data), 32'h1122);
        check("burstrd_bits", 32'(nb), 32'd16);
        check("burstrd_span", 32'(sp), 32'd16);
        check("burstrd_end_validout", 32'(ev), 32'h0);

        // Slave-ID mismatch: data bits are sent anyway.
        do_write(0, 12'h325, 0, 8'h5A, 8'h00, 1, re, rc, vc);
        check("wr325_ready_pulses", 32'(rc), 32'h0);
        check("wr325_validout", 32'(vc), 32'h0);
        do_read(0, 12'h225, 1, 0, data, fk, nb, sp, ev, dn);
        check("rd225_after_drop", 32'(data[7:0]), 32'hB5);
        check("rd225_after_drop_bits", 32'(nb), 32'h8);

        // Abort after five address bits.
        vin[0] = 1'b1;
        wen[0] = 1'b1;
        tick();
        wen[0] = 1'b0;
        mon = 0;
        for (int i = 11; i >= 7; i--) begin
            adr[0] = 1'b1;
            tick();
            mon += int'(rdy[0]) + int'(vo[0]);
        end
        vin[0] = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            mon += int'(rdy[0]) + int'(vo[0]);
        end
        check("addr_abort_quiet", 32'(mon), 32'h0);

        // Abort after three write-data bits.
        send_hdr(0, 1'b1, 12'h225);
        check("data_abort_ready", 32'(rdy[0]), 32'h1);
        tick();
        for (int b = 0; b < 3; b++) begin
            din[0] = 1'b0;
            tick();
        end
        vin[0] = 1'b0;
        repeat (3) tick();
        do_read(0, 12'h225, 1, 0, data, fk, nb, sp, ev, dn);
        check("data_abort_mem_kept", 32'(data[7:0]), 32'hB5);
        check("data_abort_first_edge", 32'(fk), 32'h3);

        // Zero-latency instance.
        do_write(1, 12'h210, 0, 8'h3C, 8'h00, 1, re, rc, vc);
        check("rl0_wr_ready_pulses", 32'(rc), 32'h1);
        do_read(1, 12'h210, 1, 0, data, fk, nb, sp, ev, dn);
        check("rl0_rd_data", 32'(data[7:0]), 32'h3C);
        check("rl0_rd_first_edge", 32'(fk), 32'h1);
        check("rl0_rd_end_validout", 32'(ev), 32'h0);

        // Asynchronous reset in the middle of a burst read.
        do_read(0, 12'h2FF, 2, 4, data, fk, nb, sp, ev, dn);
        check("midburst_validout", 32'(vo[0]), 32'h1);
        check("midburst_dataout", 32'(dout[0]), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_validout", 32'(vo[0]), 32'h0);
        check("async_rst_dataout", 32'(dout[0]), 32'h0);
        vin[0] = 1'b0;
        repeat (2) tick();
        #2 rstn = 1'b1;
        tick();
        do_read(0, 12'h2FF, 1, 0, data, fk, nb, sp, ev, dn);
        check("post_rst_data", 32'(data[7:0]), 32'h11);
        check("post_rst_bits", 32'(nb), 32'h8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
